// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer: ALU op codes,
// muldiv op codes and the sequencer state encoding.
package muldiv_unit_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             hilo_rd;
  logic             busy;
  logic             done;
  logic             stall;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, hilo_rd,
    input  busy, done, stall, div0, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, hilo_rd,
    output busy, done, stall, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One shift-and-add (multiply) or shift-and-subtract (restoring divide) iteration
// on the {P,Q} accumulator, using the ALU add/sub encoding.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] pq_i,
  input  logic [WIDTH-1:0]   md_i,
  output logic [2*WIDTH-1:0] pq_o
);

  logic [2:0]       alu_op_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH:0]   alu_s;
  logic [WIDTH:0]   sum_s;

  always_comb begin
    p_s      = pq_i[2*WIDTH-1:WIDTH];
    q_s      = pq_i[WIDTH-1:0];
    a_s      = div_i ? {p_s[WIDTH-2:0], q_s[WIDTH-1]} : p_s;
    alu_op_s = div_i ? ALU_SUB : ALU_ADD;
    // Same encoding as the EX-stage ALU; only ADD/SUB are selected here.
    case (alu_op_s)
      ALU_AND: alu_s = {1'b0, a_s & md_i};
      ALU_OR:  alu_s = {1'b0, a_s | md_i};
      ALU_ADD: alu_s = {1'b0, a_s} + {1'b0, md_i};
      ALU_LUI: alu_s = {1'b0, md_i << (WIDTH / 2)};
      ALU_SUB: alu_s = {1'b0, a_s} - {1'b0, md_i};
      ALU_SLT: alu_s = {{WIDTH{1'b0}}, $signed(a_s) < $signed(md_i)};
      default: alu_s = '0;
    endcase
    sum_s = q_s[0] ? alu_s : {1'b0, p_s};
    if (div_i) begin
      // The bit shifted out of R counts as 2^WIDTH, so it also means "no borrow".
      if (p_s[WIDTH-1] || !alu_s[WIDTH]) begin
        pq_o = {alu_s[WIDTH-1:0], q_s[WIDTH-2:0], 1'b1};
      end else begin
        pq_o = {a_s, q_s[WIDTH-2:0], 1'b0};
      end
    end else begin
      pq_o = {sum_s, q_s[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and MTHI/MTLO,
// one add/sub step per cycle, stalling the pipeline while an operation runs.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] pq_q;
  logic [WIDTH-1:0]   md_q;
  logic               div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_s;
  logic               rs_neg_s;
  logic               rt_neg_s;
  logic [WIDTH-1:0]   rs_mag_s;
  logic [WIDTH-1:0]   rt_mag_s;
  logic [2*WIDTH-1:0] pq_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .pq_i  (pq_q),
    .md_i  (md_q),
    .pq_o  (pq_s)
  );

  always_comb begin
    signed_s = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    rs_neg_s = signed_s & bus.rs[WIDTH-1];
    rt_neg_s = signed_s & bus.rt[WIDTH-1];
    rs_mag_s = rs_neg_s ? -bus.rs : bus.rs;
    rt_mag_s = rt_neg_s ? -bus.rt : bus.rt;
    prod_s   = neg_res_q ? -pq_s : pq_s;
    quo_s    = dz_q ? '1 : (neg_res_q ? -pq_s[WIDTH-1:0] : pq_s[WIDTH-1:0]);
    rem_s    = neg_rem_q ? -pq_s[2*WIDTH-1:WIDTH] : pq_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pq_q      <= '0;
      md_q      <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          state_q <= ST_IDLE;
          if (bus.start) begin
            case (bus.op)
              MD_MULT, MD_MULTU: begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b1;
                count_q   <= CW'(WIDTH - 1);
                div_q     <= 1'b0;
                pq_q      <= {{WIDTH{1'b0}}, rt_mag_s};
                md_q      <= rs_mag_s;
                neg_res_q <= rs_neg_s ^ rt_neg_s;
                neg_rem_q <= 1'b0;
                dz_q      <= 1'b0;
              end
              MD_DIV, MD_DIVU: begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b1;
                count_q   <= CW'(WIDTH - 1);
                div_q     <= 1'b1;
                pq_q      <= {{WIDTH{1'b0}}, rs_mag_s};
                md_q      <= rt_mag_s;
                neg_res_q <= rs_neg_s ^ rt_neg_s;
                neg_rem_q <= rs_neg_s;
                dz_q      <= (bus.rt == '0);
              end
              MD_MTHI: hi_q <= bus.rs;
              MD_MTLO: lo_q <= bus.rs;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          pq_q <= pq_s;
          if (count_q == '0) begin
            state_q <= ST_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            div0_q  <= div_q & dz_q;
            if (div_q) begin
              hi_q <= rem_s;
              lo_q <= quo_s;
            end else begin
              {hi_q, lo_q} <= prod_s;
            end
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.div0  = div0_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q & (bus.start | bus.hilo_rd);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of mul/div results plus
// hand-written sequences for MTHI/MTLO, mid-run requests and mid-run reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  localparam int NV = 12;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   lat;
  int   busy_bad;
  int   seen;
  int   c;
  vec_t vecs [NV];

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called in cycle 1 after an accept edge; returns the cycle done appeared in.
  task automatic wait_done(output int lat_o, output int busy_bad_o);
    int cyc;
    cyc        = 1;
    busy_bad_o = 0;
    while (!bus.done && cyc <= 40) begin
      if (!bus.busy) busy_bad_o++;
      @(posedge clk);
      #1;
      cyc++;
    end
    lat_o = cyc;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MD_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[8]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{MD_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{MD_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 1'b0};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.rs      = 32'h0;
    bus.rt      = 32'h0;
    bus.hilo_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_div0", 32'(bus.div0), 32'd0);

    // MTHI then MTLO on consecutive edges
    bus.start = 1'b1;
    bus.op    = MD_MTHI;
    bus.rs    = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("mthi_hi", bus.hi, 32'hDEADBEEF);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    bus.op = MD_MTLO;
    bus.rs = 32'h00000001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h00000001);
    chk("mtlo_hi", bus.hi, 32'hDEADBEEF);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    chk("mtlo_done", 32'(bus.done), 32'd0);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(lat, busy_bad);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      chk($sformatf("v%0d_busy_run", i), 32'(busy_bad), 32'd0);
      chk($sformatf("v%0d_busy_fin", i), 32'(bus.busy), 32'd0);
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      chk($sformatf("v%0d_div0", i), 32'(bus.div0), 32'(vecs[i].dz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Requests during RUN are stalled and ignored; the held DIVU is taken in FINISH
    issue(MD_MULTU, 32'd6, 32'd7);
    c = 1;
    while (!bus.done && c <= 40) begin
      if (c == 3) begin
        bus.start   = 1'b1;
        bus.op      = MD_MTHI;
        bus.rs      = 32'h00000055;
        bus.hilo_rd = 1'b1;
      end
      if (c == 12) begin
        bus.op      = MD_DIVU;
        bus.rs      = 32'd100;
        bus.rt      = 32'd7;
        bus.hilo_rd = 1'b0;
      end
      #1;
      if (c == 3 || c == 12) chk($sformatf("stall_c%0d", c), 32'(bus.stall), 32'd1);
      if (c == 20) chk("hi_midrun", bus.hi, vecs[NV-1].hi);
      @(posedge clk);
      #1;
      c++;
    end
    chk("midrun_latency", 32'(c), 32'd33);
    chk("midrun_hi", bus.hi, 32'd0);
    chk("midrun_lo", bus.lo, 32'd42);
    bus.hilo_rd = 1'b1;
    #1;
    chk("stall_finish", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.hilo_rd = 1'b0;
    wait_done(lat, busy_bad);
    chk("b2b_latency", 32'(lat), 32'd33);
    chk("b2b_hi", bus.hi, 32'd2);
    chk("b2b_lo", bus.lo, 32'd14);

    // Reset in cycle 10 of a DIVU
    issue(MD_DIVU, 32'h00001000, 32'd3);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_hi", bus.hi, 32'h0);
    chk("rst_mid_lo", bus.lo, 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    chk("rst_lo_kept", bus.lo, 32'h0);
    issue(MD_MULTU, 32'd6, 32'd7);
    wait_done(lat, busy_bad);
    chk("post_rst_latency", 32'(lat), 32'd33);
    chk("post_rst_hi", bus.hi, 32'd0);
    chk("post_rst_lo", bus.lo, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer with HI/LO registers for the EX stage of the pipelined MIPS CPU. It drives one shared WIDTH-bit add/subtract step per cycle, using the ALU add (3'b010) and sub (3'b110) op codes. It covers MULT, MULTU, DIV, DIVU, MTHI and MTLO, and raises a stall request so the hazard unit freezes the pipeline while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request, qualified by op
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- rs  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- rt  in  WIDTH  multiplier / divisor
- hilo_rd  in  1  EX stage holds MFHI/MFLO
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- stall  out  1  busy & (start | hilo_rd)
- div0  out  1  last completed divide had rt==0; valid while done
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, div0=0, count=0.
- FSM has three states: IDLE, RUN, FINISH.
- IDLE or FINISH with start and op in 000–011:
  - latch operand magnitudes (absolute values for signed ops) and the result signs
  - count=WIDTH-1, go RUN
- IDLE or FINISH with start and MTHI/MTLO:
  - write rs into hi or lo at that edge
  - stay in or return to IDLE; no busy, no done
- start while in RUN is ignored. Stall holds the instruction until it can be accepted.
- RUN, multiply step (2·WIDTH accumulator {P,Q}, Q initialised with multiplier):
  - if Q[0], P = P + M (ALU add, carry kept)
  - shift {carry,P,Q} right by 1
- RUN, divide step (restoring; remainder R=0, Q=dividend):
  - shift {R,Q} left by 1
  - T = R − D (ALU sub)
  - if no borrow, R=T and Q[0]=1
- count decrements each RUN cycle. On the edge where count==0, the final step completes and the state goes to FINISH.
- Entering FINISH, hi/lo are written:
  - multiply: {hi,lo} = product, two's-complement negated if the result sign is negative
  - divide: lo = quotient, hi = remainder
  - quotient negated if the operand signs differ; remainder takes the dividend's sign
- Divide by zero: hi=rs, lo={WIDTH{1}}, div0=1. Full latency is still spent.
- DIV of 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no flag).
- FINISH lasts one cycle (done=1, busy=0), then IDLE unless a new start is accepted.

## Timing
- Accept edge = cycle 0.
- busy=1 in cycles 1..WIDTH.
- done=1 and new hi/lo visible in cycle WIDTH+1. Latency is 33 cycles at WIDTH=32.
- Back-to-back: a start in FINISH is accepted, so throughput is one op per WIDTH+1 cycles.
- MTHI/MTLO: value visible the cycle after the accept edge.
- stall is combinational from busy, start and hilo_rd.
- hilo_rd with busy=0 never stalls, including in FINISH.
- Reset mid-operation: immediate clear to reset values, no done pulse, and the partial result is discarded.
- div0 is updated only entering FINISH of a divide. A multiply finish clears it.

## Structure
- Shared package holds:
  - ALU op code constants (AND 000, OR 001, ADD 010, LUI 011, SUB 110, SLT 111)
  - muldiv op code constants
  - FSM state encoding
- One sub-module, muldiv_step: combinational single-iteration add/sub-and-shift. Inputs are the mode bit, {P,Q} and M/D; outputs are the next {P,Q}. It is instantiated once.
- Sign pre/post-processing stays in muldiv_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1–32.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x12345678 / 0 → hi=0x12345678, lo=0xFFFFFFFF, div0=1 with done.
- Mid-run start (any op) and hilo_rd:
  - stall=1, the request is ignored, hi/lo unchanged until done
  - re-issue in the FINISH cycle is accepted
- MTHI 0xDEADBEEF then MTLO 0x1 in consecutive cycles → hi=0xDEADBEEF, lo=0x1, busy never set.
- Assert reset at cycle 10 of a DIVU → hi=lo=0, busy=0, no done pulse. A fresh MULTU 6×7 afterwards gives lo=42, hi=0.
